// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode-to-execute latch with priority operand forwarding and immediate select
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_insn,
  input  logic [31:0]      in_pc,
  output logic [4:0]       ctrl_readRegA,
  output logic [4:0]       ctrl_readRegB,
  input  logic [WIDTH-1:0] data_readRegA,
  input  logic [WIDTH-1:0] data_readRegB,
  input  logic             xm_we,
  input  logic [4:0]       xm_rd,
  input  logic [WIDTH-1:0] xm_data,
  input  logic             mw_we,
  input  logic [4:0]       mw_rd,
  input  logic [WIDTH-1:0] mw_data,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] data_operandA,
  output logic [WIDTH-1:0] data_operandB,
  output logic [4:0]       ctrl_ALUopcode,
  output logic [4:0]       ctrl_shiftamt,
  output logic             out_valid,
  output logic [4:0]       out_rd,
  output logic             out_we,
  output logic [31:0]      out_pc
);
  logic [4:0] w_op, w_rd, w_rs, w_rt, w_shamt, w_aluop, w_opc, w_sh, w_dst;
  logic w_is_r, w_is_i, w_is_sw, w_is_br, w_we;
  logic [WIDTH-1:0] w_imm, w_fa, w_fb, w_a, w_b;
  logic [WIDTH-1:0] r_a, r_b;
  logic [4:0] r_opc, r_sh, r_rd;
  logic r_valid, r_we;
  logic [31:0] r_pc;
  assign w_op    = in_insn[31:27];
  assign w_rd    = in_insn[26:22];
  assign w_rs    = in_insn[21:17];
  assign w_rt    = in_insn[16:12];
  assign w_shamt = in_insn[11:7];
  assign w_aluop = in_insn[6:2];
  assign w_imm   = {{(WIDTH-17){in_insn[16]}}, in_insn[16:0]};
  assign w_is_r  = w_op == 5'b00000;
  assign w_is_sw = w_op == 5'b00111;
  assign w_is_i  = w_op == 5'b00101 || w_op == 5'b01000 || w_is_sw;
  assign w_is_br = w_op == 5'b00010 || w_op == 5'b00110;
  assign ctrl_readRegA = w_is_br ? w_rd : w_rs;
  assign ctrl_readRegB = w_is_br ? w_rs : w_is_sw ? w_rd : w_rt;
  always_comb begin
    w_fa  = ctrl_readRegA == 5'd0 ? '0 :
            (xm_we && xm_rd == ctrl_readRegA) ? xm_data :
            (mw_we && mw_rd == ctrl_readRegA) ? mw_data : data_readRegA;
    w_fb  = ctrl_readRegB == 5'd0 ? '0 :
            (xm_we && xm_rd == ctrl_readRegB) ? xm_data :
            (mw_we && mw_rd == ctrl_readRegB) ? mw_data : data_readRegB;
    w_a   = (w_is_r || w_is_i || w_is_br) ? w_fa : '0;
    w_b   = (w_is_r || w_is_br) ? w_fb : w_is_i ? w_imm : '0;
    w_opc = w_is_r ? w_aluop : w_is_br ? 5'b00001 : 5'b00000;
    w_sh  = w_is_r ? w_shamt : 5'd0;
    w_we  = w_is_r || (w_is_i && !w_is_sw);
    w_dst = w_we ? w_rd : 5'd0;
  end
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_a     <= '0;
      r_b     <= '0;
      r_opc   <= '0;
      r_sh    <= '0;
      r_valid <= 1'b0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_pc    <= '0;
    end else if (!stall) begin
      r_a     <= in_valid ? w_a : '0;
      r_b     <= in_valid ? w_b : '0;
      r_opc   <= in_valid ? w_opc : '0;
      r_sh    <= in_valid ? w_sh : '0;
      r_valid <= in_valid;
      r_rd    <= in_valid ? w_dst : '0;
      r_we    <= in_valid && w_we;
      r_pc    <= in_valid ? in_pc : '0;
    end
  end
  assign data_operandA  = r_a;
  assign data_operandB  = r_b;
  assign ctrl_ALUopcode = r_opc;
  assign ctrl_shiftamt  = r_sh;
  assign out_valid      = r_valid;
  assign out_rd         = r_rd;
  assign out_we         = r_we;
  assign out_pc         = r_pc;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
  logic clock = 0, reset = 0, in_valid = 0, xm_we = 0, mw_we = 0, stall = 0, flush = 0;
  logic [31:0] in_insn = 0, in_pc = 0, data_readRegA = 0, data_readRegB = 0, xm_data = 0, mw_data = 0;
  logic [4:0] xm_rd = 0, mw_rd = 0;
  logic [4:0] ctrl_readRegA, ctrl_readRegB, ctrl_ALUopcode, ctrl_shiftamt, out_rd;
  logic [31:0] data_operandA, data_operandB, out_pc;
  logic out_valid, out_we;
  logic [112:0] obs, expv;
  int vectors = 0, errors = 0;
  alu_issue_stage #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB),
    .xm_we(xm_we), .xm_rd(xm_rd), .xm_data(xm_data),
    .mw_we(mw_we), .mw_rd(mw_rd), .mw_data(mw_data),
    .stall(stall), .flush(flush),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_ALUopcode(ctrl_ALUopcode), .ctrl_shiftamt(ctrl_shiftamt),
    .out_valid(out_valid), .out_rd(out_rd), .out_we(out_we), .out_pc(out_pc)
  );
  always #5 clock = ~clock;
  assign obs = {data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt, out_valid, out_rd, out_we, out_pc};
  function automatic logic [112:0] pack(input logic [31:0] a, b, input logic [4:0] op, sh,
                                         input logic v, input logic [4:0] rd, input logic we, input logic [31:0] pc);
    return {a, b, op, sh, v, rd, we, pc};
  endfunction
  function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, sh, aluop);
    return {5'd0, rd, rs, rt, sh, aluop, 2'b00};
  endfunction
  function automatic logic [31:0] itype(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1; in_valid = 1; in_insn = 32'h0523_4A10; in_pc = 32'hCAFE_F00D;
    data_readRegA = 32'h1234_5678; data_readRegB = 32'h9ABC_DEF0;
    xm_we = 1; xm_rd = 5'd3; xm_data = 32'hAAAA_5555; mw_we = 1; mw_rd = 5'd7; mw_data = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (obs !== 113'd0) begin errors++; $display("FAIL reset_edge%0d got=%h want=0", k, obs); end
    end
    reset = 0; in_valid = 0;
    step();
    vectors++;
    if (obs !== 113'd0) begin errors++; $display("FAIL reset_release_invalid got=%h want=0", obs); end
    xm_we = 0; mw_we = 0;
  endtask
  task automatic test_add_forward();
    in_valid = 1; in_insn = rtype(5'd3, 5'd1, 5'd2, 5'd0, 5'd0); in_pc = 32'h100;
    data_readRegA = 5; data_readRegB = 7;
    xm_we = 1; xm_rd = 5'd2; xm_data = 100; mw_we = 1; mw_rd = 5'd2; mw_data = 50;
    #1;
    vectors++;
    if ({ctrl_readRegA, ctrl_readRegB} !== {5'd1, 5'd2}) begin
      errors++; $display("FAIL add_readregs got=%0d/%0d want=1/2", ctrl_readRegA, ctrl_readRegB);
    end
    step();
    expv = pack(32'd5, 32'd100, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 32'h100);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL add_double_match got=%h want=%h", obs, expv); end
    in_insn = rtype(5'd7, 5'd2, 5'd1, 5'd0, 5'd1); in_pc = 32'h104;
    data_readRegA = 7; data_readRegB = 5; xm_rd = 5'd9; mw_rd = 5'd2;
    step();
    expv = pack(32'd50, 32'd5, 5'd1, 5'd0, 1'b1, 5'd7, 1'b1, 32'h104);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL sub_mw_forward got=%h want=%h", obs, expv); end
  endtask
  task automatic test_immediate();
    in_insn = itype(5'b00101, 5'd4, 5'd0, 17'h1FFFF); in_pc = 32'h108;
    data_readRegA = 32'hDEAD; xm_we = 1; xm_rd = 5'd0; xm_data = 9; mw_we = 1; mw_rd = 5'd0; mw_data = 9;
    step();
    expv = pack(32'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 32'h108);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL addi_neg got=%h want=%h", obs, expv); end
    in_insn = itype(5'b00111, 5'd9, 5'd3, 17'h00010); in_pc = 32'h10C;
    data_readRegA = 20; xm_we = 0; mw_we = 0;
    #1;
    vectors++;
    if ({ctrl_readRegA, ctrl_readRegB} !== {5'd3, 5'd9}) begin
      errors++; $display("FAIL sw_readregs got=%0d/%0d want=3/9", ctrl_readRegA, ctrl_readRegB);
    end
    step();
    expv = pack(32'd20, 32'd16, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h10C);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL sw_decode got=%h want=%h", obs, expv); end
  endtask
  task automatic test_branch();
    in_insn = itype(5'b00110, 5'd5, 5'd6, 17'd0); in_pc = 32'h110;
    data_readRegA = 8; data_readRegB = 77; xm_we = 0; mw_we = 1; mw_rd = 5'd6; mw_data = 3;
    #1;
    vectors++;
    if ({ctrl_readRegA, ctrl_readRegB} !== {5'd5, 5'd6}) begin
      errors++; $display("FAIL blt_readregs got=%0d/%0d want=5/6", ctrl_readRegA, ctrl_readRegB);
    end
    step();
    expv = pack(32'd8, 32'd3, 5'd1, 5'd0, 1'b1, 5'd0, 1'b0, 32'h110);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL blt_decode got=%h want=%h", obs, expv); end
    in_insn = {5'b11111, 27'h5A5_A5A5}; in_pc = 32'h114; mw_we = 0;
    step();
    expv = pack(32'd0, 32'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 32'h114);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL unknown_op got=%h want=%h", obs, expv); end
  endtask
  task automatic test_stall_flush();
    in_insn = rtype(5'd1, 5'd2, 5'd0, 5'd4, 5'b00100); in_pc = 32'h200;
    data_readRegA = 11; data_readRegB = 99;
    step();
    expv = pack(32'd11, 32'd0, 5'd4, 5'd4, 1'b1, 5'd1, 1'b1, 32'h200);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL sll_load got=%h want=%h", obs, expv); end
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      in_insn = rtype(5'd10 + 5'(k), 5'd3, 5'd4, 5'd1, 5'd2); in_pc = 32'h300 + k; data_readRegA = 40 + k;
      step();
      vectors++;
      if (obs !== expv) begin errors++; $display("FAIL stall_hold%0d got=%h want=%h", k, obs, expv); end
    end
    flush = 1;
    step();
    vectors++;
    if (obs !== 113'd0) begin errors++; $display("FAIL stall_and_flush got=%h want=0", obs); end
    stall = 0; flush = 0;
    in_insn = rtype(5'd12, 5'd3, 5'd4, 5'd0, 5'd2); in_pc = 32'h304; data_readRegA = 6; data_readRegB = 2;
    step();
    expv = pack(32'd6, 32'd2, 5'd2, 5'd0, 1'b1, 5'd12, 1'b1, 32'h304);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL release_load got=%h want=%h", obs, expv); end
  endtask
  task automatic test_reset_midstream();
    stall = 1; reset = 1; in_valid = 1;
    step();
    vectors++;
    if (obs !== 113'd0) begin errors++; $display("FAIL reset_mid_stall got=%h want=0", obs); end
    reset = 0; stall = 0;
    in_insn = itype(5'b01000, 5'd8, 5'd3, 17'h00004); in_pc = 32'h400; data_readRegA = 32'h1000;
    step();
    expv = pack(32'h1000, 32'd4, 5'd0, 5'd0, 1'b1, 5'd8, 1'b1, 32'h400);
    vectors++;
    if (obs !== expv) begin errors++; $display("FAIL post_reset_load got=%h want=%h", obs, expv); end
    in_valid = 0;
    step();
    vectors++;
    if (obs !== 113'd0) begin errors++; $display("FAIL invalid_bubble got=%h want=0", obs); end
  endtask
  initial begin
    #2;
    test_reset();
    test_add_forward();
    test_immediate();
    test_branch();
    test_stall_flush();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
